// File: rtl/pipe_hazard_ctrl.sv
// Hazard and halt control for a 5-stage MIPS pipeline.
// Covers load-use stalls, redirect flushes, EX forwarding selects and the halt/drain sequencer.
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_use_rs_i,
    input  logic             id_use_rt_i,
    input  logic [4:0]       ex_rs_i,
    input  logic [4:0]       ex_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             mem_regwrite_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             wb_regwrite_i,
    input  logic [4:0]       wb_rd_i,
    input  logic             redirect_i,
    input  logic             halt_req_i,
    output logic             pc_write_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_dbg_o
);

    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DC_W-1:0] drain_cnt;
    logic [DC_W-1:0] drain_cnt_next;
    logic            lu;
    logic            stall;

    // The load sits in EX one cycle ahead of its consumer in ID.
    assign lu = ex_memread_i && (ex_rd_i != 5'd0) &&
                ((id_use_rs_i && (ex_rd_i == id_rs_i)) ||
                 (id_use_rt_i && (ex_rd_i == id_rt_i)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       m_we,
                                           input logic [4:0] m_rd,
                                           input logic       w_we,
                                           input logic [4:0] w_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a_o = fwd_sel(ex_rs_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);
    assign fwd_b_o = fwd_sel(ex_rt_i, mem_regwrite_i, mem_rd_i, wb_regwrite_i, wb_rd_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted_o  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted_o  <= (state_next == ST_HALTED);
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            ST_RUN: begin
                // A redirect in flight defers the halt by one cycle.
                if (halt_req_i && !redirect_i) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!halt_req_i) begin
                    state_next     = ST_RUN;
                    drain_cnt_next = '0;
                end else if (redirect_i) begin
                    drain_cnt_next = DRAIN_LOAD;
                end else if (lu) begin
                    drain_cnt_next = drain_cnt;
                end else if (drain_cnt <= DC_W'(1)) begin
                    state_next     = ST_HALTED;
                    drain_cnt_next = '0;
                end else begin
                    drain_cnt_next = drain_cnt - DC_W'(1);
                end
            end
            ST_HALTED: begin
                if (!halt_req_i) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next     = ST_RUN;
                drain_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_hold_o   = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        stall         = 1'b0;
        case (state)
            ST_RUN: begin
                if (redirect_i) begin
                    ifid_flush_o  = 1'b1;
                    idex_flush_o  = 1'b1;
                    exmem_flush_o = 1'b1;
                end else if (lu) begin
                    pc_write_o   = 1'b0;
                    ifid_hold_o  = 1'b1;
                    idex_flush_o = 1'b1;
                    stall        = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Fetch is blocked; only a redirect may still move the PC.
                ifid_flush_o = 1'b1;
                pc_write_o   = redirect_i;
                if (redirect_i) begin
                    idex_flush_o  = 1'b1;
                    exmem_flush_o = 1'b1;
                end else if (lu) begin
                    ifid_hold_o  = 1'b1;
                    idex_flush_o = 1'b1;
                    stall        = 1'b1;
                end
            end
            ST_HALTED: begin
                pc_write_o  = 1'b0;
                ifid_hold_o = 1'b1;
            end
            default: begin
                pc_write_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (redirect_i && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

    assign state_dbg_o = state;

endmodule
